// File: rtl/adc_config_sequencer_pkg.sv
// Shared encodings for the ADC configuration sequencer: FSM states, serializer
// status bit positions and command-table field layout.
package adc_config_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } seqState_t;

    localparam int SER_BUSY_HI = 31;
    localparam int SER_BUSY_LO = 30;

    localparam int MASK_HI = 25;
    localparam int MASK_LO = 24;
    localparam int WORD_W  = 24;
    localparam int ENTRY_W = 26;

    // Serializer control word: ADC2/ADC1 select in the top two bits, payload in the low 24.
    function automatic logic [31:0] buildSerData(input logic [ENTRY_W-1:0] entry);
        return {entry[MASK_HI], entry[MASK_LO], 6'b000000, entry[WORD_W-1:0]};
    endfunction

endpackage

// File: rtl/adc_cmd_table.sv
// Command table: register array with one write port and a combinational read.
// Contents are deliberately not reset.
module adc_cmd_table
    import adc_config_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic               CLK,
    input  logic               wrEn,
    input  logic [ADDR_W-1:0]  wrAddr,
    input  logic [ENTRY_W-1:0] wrData,
    input  logic [ADDR_W-1:0]  rdAddr,
    output logic [ENTRY_W-1:0] rdData
);

    logic [ENTRY_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/adc_config_sequencer.sv
// Walks the command table, writing each entry to the ADC configuration serializer,
// polling its busy bits for completion and spacing commands by a fixed gap.
module adc_config_sequencer
    import adc_config_sequencer_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int ACK_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic              TBL_WE,
    input  logic [ADDR_W-1:0] TBL_ADDR,
    input  logic [25:0]       TBL_WDATA,
    input  logic              GO,
    input  logic [ADDR_W:0]   COUNT,
    input  logic              ABORT,
    output logic              SER_CEb,
    output logic              SER_WEb,
    output logic [31:0]       SER_DATA,
    input  logic [31:0]       SER_STATUS,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR_TIMEOUT,
    output logic [ADDR_W:0]   CUR_INDEX
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);

    seqState_t          state;
    logic [ADDR_W:0]    numEntries;
    logic [31:0]        timer;
    logic               skipGap;
    logic               finishEmpty;
    logic [ENTRY_W-1:0] entry;
    logic               serBusy;
    logic               unusedStatusBits;

    assign serBusy          = |SER_STATUS[SER_BUSY_HI:SER_BUSY_LO];
    assign unusedStatusBits = ^SER_STATUS[SER_BUSY_LO-1:0];

    adc_cmd_table #(.ADDR_W(ADDR_W)) uTable (
        .CLK    (CLK),
        .wrEn   (TBL_WE && !BUSY),
        .wrAddr (TBL_ADDR),
        .wrData (TBL_WDATA),
        .rdAddr (CUR_INDEX[ADDR_W-1:0]),
        .rdData (entry)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state       <= IDLE;
            SER_CEb     <= 1'b1;
            SER_WEb     <= 1'b1;
            SER_DATA    <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            CUR_INDEX   <= '0;
            numEntries  <= '0;
            timer       <= '0;
            skipGap     <= 1'b0;
            finishEmpty <= 1'b0;
        end else if (ABORT) begin
            // Serializer finishes any frame it already started; we just stop feeding it.
            state       <= IDLE;
            BUSY        <= 1'b0;
            SER_CEb     <= 1'b1;
            SER_WEb     <= 1'b1;
            finishEmpty <= 1'b0;
        end else begin
            SER_CEb <= 1'b1;
            SER_WEb <= 1'b1;
            case (state)
                IDLE: begin
                    if (finishEmpty) begin
                        DONE        <= 1'b1;
                        finishEmpty <= 1'b0;
                    end
                    if (GO) begin
                        DONE        <= 1'b0;
                        ERR_TIMEOUT <= 1'b0;
                        CUR_INDEX   <= '0;
                        numEntries  <= (COUNT > DEPTH_CNT) ? DEPTH_CNT : COUNT;
                        if (COUNT == '0) begin
                            finishEmpty <= 1'b1;
                        end else begin
                            BUSY  <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    if (entry[MASK_HI:MASK_LO] == 2'b00) begin
                        CUR_INDEX <= CUR_INDEX + 1'b1;
                        skipGap   <= 1'b1;
                        state     <= GAP;
                    end else begin
                        SER_CEb  <= 1'b0;
                        SER_WEb  <= 1'b0;
                        SER_DATA <= buildSerData(entry);
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (serBusy) begin
                        timer <= '0;
                        state <= WAIT_DONE;
                    end else if (timer == 32'(ACK_CYCLES - 1)) begin
                        ERR_TIMEOUT <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!serBusy) begin
                        CUR_INDEX <= CUR_INDEX + 1'b1;
                        timer     <= '0;
                        skipGap   <= 1'b0;
                        state     <= GAP;
                    end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                        ERR_TIMEOUT <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                GAP: begin
                    if (skipGap || timer == 32'(GAP_CYCLES - 1)) begin
                        if (CUR_INDEX == numEntries) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_config_sequencer.sv
// Randomised bench for adc_config_sequencer with a behavioural serializer and a
// table-driven reference of which words must be written.
module tb_adc_config_sequencer;

    localparam int ADDR_W         = 4;
    localparam int GAP_CYCLES     = 16;
    localparam int ACK_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int DEPTH          = 2**ADDR_W;

    logic              CLK = 1'b0;
    logic              RSTb = 1'b0;
    logic              TBL_WE = 1'b0;
    logic [ADDR_W-1:0] TBL_ADDR = '0;
    logic [25:0]       TBL_WDATA = '0;
    logic              GO = 1'b0;
    logic [ADDR_W:0]   COUNT = '0;
    logic              ABORT = 1'b0;
    logic              SER_CEb, SER_WEb;
    logic [31:0]       SER_DATA;
    logic [31:0]       SER_STATUS;
    logic              BUSY, DONE, ERR_TIMEOUT;
    logic [ADDR_W:0]   CUR_INDEX;

    int nCmp = 0;
    int nBad = 0;
    int cyc = 0;

    logic [25:0] model [DEPTH];
    logic [33:0] obsQ [$];
    int          cycQ [$];

    // Serializer behaviour: 0 = normal, 1 = never goes busy, 2 = busy stuck high.
    int       serMode = 0;
    int       serFixLen = 0;
    bit       serPend, serBusy;
    int       serCnt;
    logic [1:0] serMask;

    adc_config_sequencer #(
        .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES),
        .ACK_CYCLES(ACK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR),
        .TBL_WDATA(TBL_WDATA), .GO(GO), .COUNT(COUNT), .ABORT(ABORT),
        .SER_CEb(SER_CEb), .SER_WEb(SER_WEb), .SER_DATA(SER_DATA),
        .SER_STATUS(SER_STATUS), .BUSY(BUSY), .DONE(DONE),
        .ERR_TIMEOUT(ERR_TIMEOUT), .CUR_INDEX(CUR_INDEX)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe monitor plus serializer model, both away from the active edge.
    always @(negedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            serPend = 1'b0; serBusy = 1'b0; serCnt = 0; serMask = 2'b00;
            SER_STATUS = '0;
        end else begin
            if (!SER_WEb || !SER_CEb) begin
                obsQ.push_back({SER_CEb, SER_WEb, SER_DATA});
                cycQ.push_back(cyc);
            end
            if (!SER_WEb && !SER_CEb && serMode != 1) begin
                serPend = 1'b1;
                serMask = SER_DATA[31:30];
                serCnt  = (serMode == 2) ? 0 : $urandom_range(0, 2);
            end else if (serPend) begin
                if (serCnt == 0) begin
                    serPend = 1'b0;
                    serBusy = 1'b1;
                    serCnt  = (serFixLen != 0) ? serFixLen : $urandom_range(1, 40);
                end else begin
                    serCnt--;
                end
            end else if (serBusy && serMode != 2) begin
                if (serCnt <= 1) serBusy = 1'b0;
                else serCnt--;
            end
            SER_STATUS = {(serBusy ? serMask : 2'b00), 30'($urandom)};
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
        #1;
    endtask

    task automatic writeEntry(input int addr, input logic [25:0] data);
        TBL_ADDR = ADDR_W'(addr); TBL_WDATA = data; TBL_WE = 1'b1;
        tick;
        TBL_WE = 1'b0;
        model[addr] = data;
    endtask

    task automatic waitSerIdle;
        int budget = 0;
        while ((serPend || serBusy) && budget < 300) begin
            tick; budget++;
        end
        checkEq("ser_idle_bound", 64'(budget < 300), 64'(1));
    endtask

    task automatic runSeq(input int cnt, input bit noise);
        logic [31:0] expQ [$];
        int n, base, goCyc, budget, nObs;
        bit busySeen;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < n; i++)
            if (model[i][25:24] != 2'b00) expQ.push_back({model[i][25:24], 6'b0, model[i][23:0]});
        waitSerIdle();
        base = obsQ.size();
        COUNT = (ADDR_W+1)'(cnt); GO = 1'b1;
        tick;
        GO = 1'b0; goCyc = cyc; busySeen = BUSY;
        checkEq("go_busy", 64'(BUSY), 64'(n > 0));
        checkEq("go_index", 64'(CUR_INDEX), 64'(0));
        if (n > 0) checkEq("go_done_clr", 64'(DONE), 64'(0));
        budget = 0;
        while (BUSY && budget < 4000) begin
            if (noise) begin
                TBL_WE = ($urandom_range(0, 3) == 0);
                TBL_ADDR = ADDR_W'($urandom_range(0, DEPTH-1));
                TBL_WDATA = 26'($urandom);
                if (budget == 3) begin GO = 1'b1; COUNT = (ADDR_W+1)'($urandom); end
            end
            tick;
            TBL_WE = 1'b0; GO = 1'b0; budget++;
        end
        tick;
        checkEq("run_bound", 64'(budget < 4000), 64'(1));
        checkEq("busy_seen", 64'(busySeen), 64'(n > 0));
        checkEq("end_done", 64'(DONE), 64'(1));
        checkEq("end_err", 64'(ERR_TIMEOUT), 64'(0));
        checkEq("end_busy", 64'(BUSY), 64'(0));
        checkEq("end_index", 64'(CUR_INDEX), 64'(n));
        nObs = obsQ.size() - base;
        checkEq("n_writes", 64'(nObs), 64'(expQ.size()));
        for (int i = 0; i < nObs && i < expQ.size(); i++)
            checkEq("wr_data", 64'(obsQ[base+i]), 64'({2'b00, expQ[i]}));
        for (int i = 1; i < nObs; i++)
            checkEq("wr_spacing", 64'(cycQ[base+i] - cycQ[base+i-1] >= GAP_CYCLES), 64'(1));
        if (n > 0 && model[0][25:24] != 2'b00 && nObs > 0)
            checkEq("first_latency", 64'(cycQ[base] - goCyc), 64'(1));
    endtask

    task automatic runErr(input int mode, input int expDelta, input string tag);
        int base, errCyc, budget;
        waitSerIdle();
        serMode = mode; base = obsQ.size();
        COUNT = (ADDR_W+1)'(1); GO = 1'b1;
        tick;
        GO = 1'b0; errCyc = -1; budget = 0;
        while (BUSY && budget < 500) begin
            tick; budget++;
            if (ERR_TIMEOUT && errCyc < 0) errCyc = cyc;
        end
        checkEq({tag, "_bound"}, 64'(budget < 500), 64'(1));
        checkEq({tag, "_err"}, 64'(ERR_TIMEOUT), 64'(1));
        checkEq({tag, "_done"}, 64'(DONE), 64'(0));
        checkEq({tag, "_busy"}, 64'(BUSY), 64'(0));
        checkEq({tag, "_index"}, 64'(CUR_INDEX), 64'(0));
        checkEq({tag, "_strobes"}, 64'(obsQ.size() - base), 64'(1));
        if (obsQ.size() == base + 1)
            checkEq({tag, "_delay"}, 64'(errCyc - cycQ[base]), 64'(expDelta));
        serMode = 0;
    endtask

    initial begin
        int base, budget;

        repeat (3) tick;
        RSTb = 1'b1;
        tick;
        checkEq("rst_ceb", 64'(SER_CEb), 64'(1));
        checkEq("rst_web", 64'(SER_WEb), 64'(1));
        checkEq("rst_data", 64'(SER_DATA), 64'(0));
        checkEq("rst_busy", 64'(BUSY), 64'(0));
        checkEq("rst_done", 64'(DONE), 64'(0));
        checkEq("rst_err", 64'(ERR_TIMEOUT), 64'(0));
        checkEq("rst_index", 64'(CUR_INDEX), 64'(0));

        // Two-entry sequence, then an empty sequence, then a skipped entry.
        writeEntry(0, 26'h1ABCDEF);
        writeEntry(1, 26'h2123456);
        runSeq(2, 1'b0);
        runSeq(0, 1'b0);
        writeEntry(0, 26'h0000055);
        writeEntry(1, 26'h3000001);
        runSeq(2, 1'b0);

        // Acknowledge timeout, then completion timeout with busy stuck high.
        writeEntry(0, 26'h1000ABC);
        runErr(1, ACK_CYCLES, "ack_to");
        runErr(2, TIMEOUT_CYCLES + 2, "done_to");

        // Abort while entry 1 of 4 is being serialized; writes during the run are ignored.
        for (int i = 0; i < 4; i++)
            writeEntry(i, {2'($urandom_range(1, 3)), 24'($urandom)});
        waitSerIdle();
        serFixLen = 30; base = obsQ.size();
        COUNT = (ADDR_W+1)'(4); GO = 1'b1;
        tick;
        GO = 1'b0; budget = 0;
        while (obsQ.size() < base + 2 && budget < 300) begin
            TBL_WE = 1'b1; TBL_ADDR = ADDR_W'($urandom_range(0, 3)); TBL_WDATA = 26'($urandom);
            tick;
            TBL_WE = 1'b0; budget++;
        end
        checkEq("abort_bound", 64'(budget < 300), 64'(1));
        repeat (5) tick;
        ABORT = 1'b1;
        tick;
        ABORT = 1'b0;
        checkEq("abort_busy", 64'(BUSY), 64'(0));
        checkEq("abort_done", 64'(DONE), 64'(0));
        checkEq("abort_err", 64'(ERR_TIMEOUT), 64'(0));
        checkEq("abort_web", 64'(SER_WEb), 64'(1));
        repeat (80) tick;
        checkEq("abort_strobes", 64'(obsQ.size() - base), 64'(2));
        serFixLen = 0;
        runSeq(4, 1'b0);

        // ABORT beats GO in the same idle cycle.
        base = obsQ.size();
        COUNT = (ADDR_W+1)'(4); GO = 1'b1; ABORT = 1'b1;
        tick;
        GO = 1'b0; ABORT = 1'b0;
        checkEq("abort_go_busy", 64'(BUSY), 64'(0));
        checkEq("abort_go_done", 64'(DONE), 64'(1));
        repeat (5) tick;
        checkEq("abort_go_strobes", 64'(obsQ.size() - base), 64'(0));

        // Asynchronous reset in the middle of the inter-command gap.
        writeEntry(0, 26'h200F00D);
        writeEntry(1, 26'h10BEEF0);
        waitSerIdle();
        serFixLen = 10; base = obsQ.size();
        COUNT = (ADDR_W+1)'(2); GO = 1'b1;
        tick;
        GO = 1'b0; budget = 0;
        while (obsQ.size() == base && budget < 100) begin
            tick; budget++;
        end
        checkEq("gap_strobe_bound", 64'(budget < 100), 64'(1));
        repeat (20) tick;
        checkEq("pre_rst_busy", 64'(BUSY), 64'(1));
        checkEq("pre_rst_index", 64'(CUR_INDEX), 64'(1));
        #2 RSTb = 1'b0;
        #1;
        checkEq("arst_ceb", 64'(SER_CEb), 64'(1));
        checkEq("arst_web", 64'(SER_WEb), 64'(1));
        checkEq("arst_data", 64'(SER_DATA), 64'(0));
        checkEq("arst_busy", 64'(BUSY), 64'(0));
        checkEq("arst_done", 64'(DONE), 64'(0));
        checkEq("arst_err", 64'(ERR_TIMEOUT), 64'(0));
        checkEq("arst_index", 64'(CUR_INDEX), 64'(0));
        tick;
        RSTb = 1'b1;
        serFixLen = 0;
        tick;
        runSeq(2, 1'b0);

        // Random tables (including skipped entries), random COUNT, bus noise during runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++)
                writeEntry(i, {2'($urandom_range(0, 3)), 24'($urandom)});
            runSeq($urandom_range(0, 2*DEPTH - 1), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
